// File: rtl/huffman_ctrl_pkg.sv
// Shared types and constants for the Huffman code builder: FSM states,
// entry layout ({count, symbol-flags}) and the inactive-entry sentinel.
package huffman_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    MERGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_SYM     = 6;
  localparam int CNT_W       = 8;
  localparam int FLAG_W      = 7;
  localparam int ENTRY_W     = CNT_W + FLAG_W;
  localparam int MERGE_STEPS = 5;

  // Flag bit 6 is never owned by a real symbol, so the sentinel outranks
  // every real entry even when that entry's count is 8'hFF.
  localparam logic [ENTRY_W-1:0] SENT_DEFAULT = {8'hFF, 7'h40};

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [CNT_W-1:0] cnt,
                                                    input int idx);
    logic [FLAG_W-1:0] flag;
    flag = FLAG_W'(1) << idx;
    return {cnt, flag};
  endfunction

endpackage

// File: rtl/huffman_ctrl_pe.sv
// Combinational sorter/merger: orders six entries largest-first and forms
// the merged entry of the two smallest (summed count, OR-ed symbol flags).
module huffman_ctrl_pe
  import huffman_ctrl_pkg::*;
(
  input  logic [14:0] i_e1,
  input  logic [14:0] i_e2,
  input  logic [14:0] i_e3,
  input  logic [14:0] i_e4,
  input  logic [14:0] i_e5,
  input  logic [14:0] i_e6,
  output logic [14:0] o_s1,
  output logic [14:0] o_s2,
  output logic [14:0] o_s3,
  output logic [14:0] o_s4,
  output logic [14:0] o_s5,
  output logic [14:0] o_s6,
  output logic [14:0] o_merged
);

  logic [ENTRY_W-1:0] w_arr [NUM_SYM];
  logic [ENTRY_W-1:0] w_tmp;

  // Full 15-bit compare: ties on count are broken by the flag field, which
  // keeps the ordering deterministic.
  always_comb begin
    // NOTE: every always_comb variable gets a value before any branch, so no latch is inferred.
    w_tmp    = '0;
    w_arr[0] = i_e1;
    w_arr[1] = i_e2;
    w_arr[2] = i_e3;
    w_arr[3] = i_e4;
    w_arr[4] = i_e5;
    w_arr[5] = i_e6;
    for (int pass = 0; pass < NUM_SYM - 1; pass++) begin
      for (int j = 0; j < NUM_SYM - 1; j++) begin
        if (w_arr[j] < w_arr[j+1]) begin
          w_tmp      = w_arr[j];
          w_arr[j]   = w_arr[j+1];
          w_arr[j+1] = w_tmp;
        end
      end
    end
  end

  assign o_s1 = w_arr[0];
  assign o_s2 = w_arr[1];
  assign o_s3 = w_arr[2];
  assign o_s4 = w_arr[3];
  assign o_s5 = w_arr[4];
  assign o_s6 = w_arr[5];

  assign o_merged = {w_arr[4][ENTRY_W-1:FLAG_W] + w_arr[5][ENTRY_W-1:FLAG_W],
                     w_arr[4][FLAG_W-1:0] | w_arr[5][FLAG_W-1:0]};

endmodule

// File: rtl/huffman_ctrl.sv
// Counts a stream of symbols 1..6, then builds their Huffman codes in five
// merge steps using one combinational sorter/merger per cycle.
module huffman_ctrl
  import huffman_ctrl_pkg::*;
#(
  parameter logic [14:0] SENT = SENT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gray_valid,
  input  logic [7:0] gray_data,
  output logic       CNT_valid,
  output logic [7:0] CNT1,
  output logic [7:0] CNT2,
  output logic [7:0] CNT3,
  output logic [7:0] CNT4,
  output logic [7:0] CNT5,
  output logic [7:0] CNT6,
  output logic       code_valid,
  output logic [7:0] HC1,
  output logic [7:0] HC2,
  output logic [7:0] HC3,
  output logic [7:0] HC4,
  output logic [7:0] HC5,
  output logic [7:0] HC6,
  output logic [7:0] M1,
  output logic [7:0] M2,
  output logic [7:0] M3,
  output logic [7:0] M4,
  output logic [7:0] M5,
  output logic [7:0] M6
);

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt   [NUM_SYM];
  logic [CNT_W-1:0]   r_hc    [NUM_SYM];
  logic [CNT_W-1:0]   r_m     [NUM_SYM];
  logic [ENTRY_W-1:0] r_entry [NUM_SYM];
  logic [CNT_W-1:0]   r_total;
  logic [2:0]         r_step;
  logic               r_cnt_valid;
  logic               r_code_valid;

  logic               w_legal;
  logic [2:0]         w_idx;
  logic               w_last_step;
  logic [ENTRY_W-1:0] w_s1, w_s2, w_s3, w_s4, w_s5, w_s6, w_merged;

  assign w_legal     = (gray_data >= 8'd1) && (gray_data <= 8'd6);
  assign w_idx       = gray_data[2:0] - 3'd1;
  assign w_last_step = (r_step == 3'(MERGE_STEPS));

  huffman_ctrl_pe u_pe (
    .i_e1     (r_entry[0]),
    .i_e2     (r_entry[1]),
    .i_e3     (r_entry[2]),
    .i_e4     (r_entry[3]),
    .i_e5     (r_entry[4]),
    .i_e6     (r_entry[5]),
    .o_s1     (w_s1),
    .o_s2     (w_s2),
    .o_s3     (w_s3),
    .o_s4     (w_s4),
    .o_s5     (w_s5),
    .o_s6     (w_s6),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (gray_valid)  w_next = COUNT;
      COUNT:   if (!gray_valid) w_next = MERGE;
      MERGE:   if (w_last_step) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: these small register arrays are cleared in reset because a mid-run abort must leave zeros on every output.
      for (int i = 0; i < NUM_SYM; i++) begin
        r_cnt[i]   <= '0;
        r_hc[i]    <= '0;
        r_m[i]     <= '0;
        r_entry[i] <= '0;
      end
      r_total      <= '0;
      r_step       <= '0;
      r_cnt_valid  <= 1'b0;
      r_code_valid <= 1'b0;
    end else begin
      r_cnt_valid  <= 1'b0;
      r_code_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (gray_valid) begin
            for (int i = 0; i < NUM_SYM; i++) r_cnt[i] <= '0;
            r_total <= '0;
            if (w_legal) begin
              r_cnt[w_idx] <= 8'd1;
              r_total      <= 8'd1;
            end
          end
        end
        COUNT: begin
          if (gray_valid) begin
            if (w_legal && (r_total != 8'hFF)) begin
              r_cnt[w_idx] <= r_cnt[w_idx] + 8'd1;
              r_total      <= r_total + 8'd1;
            end
          end else begin
            for (int i = 0; i < NUM_SYM; i++) begin
              r_entry[i] <= make_entry(r_cnt[i], i);
              r_hc[i]    <= '0;
              r_m[i]     <= '0;
            end
            r_step      <= 3'd1;
            r_cnt_valid <= 1'b1;
          end
        end
        MERGE: begin
          // M is 2^len-1, so M+1 is exactly the bit at the current code length.
          for (int i = 0; i < NUM_SYM; i++) begin
            if (w_s6[i]) begin
              r_hc[i] <= r_hc[i] | (r_m[i] + 8'd1);
              r_m[i]  <= {r_m[i][CNT_W-2:0], 1'b1};
            end else if (w_s5[i]) begin
              r_m[i]  <= {r_m[i][CNT_W-2:0], 1'b1};
            end
          end
          r_entry[0]   <= w_s1;
          r_entry[1]   <= w_s2;
          r_entry[2]   <= w_s3;
          r_entry[3]   <= w_s4;
          r_entry[4]   <= w_merged;
          r_entry[5]   <= SENT;
          r_step       <= r_step + 3'd1;
          r_code_valid <= w_last_step;
        end
        default: ;
      endcase
    end
  end

  assign CNT_valid  = r_cnt_valid;
  assign code_valid = r_code_valid;

  assign CNT1 = r_cnt[0];
  assign CNT2 = r_cnt[1];
  assign CNT3 = r_cnt[2];
  assign CNT4 = r_cnt[3];
  assign CNT5 = r_cnt[4];
  assign CNT6 = r_cnt[5];

  assign HC1 = r_hc[0];
  assign HC2 = r_hc[1];
  assign HC3 = r_hc[2];
  assign HC4 = r_hc[3];
  assign HC5 = r_hc[4];
  assign HC6 = r_hc[5];

  assign M1 = r_m[0];
  assign M2 = r_m[1];
  assign M3 = r_m[2];
  assign M4 = r_m[3];
  assign M5 = r_m[4];
  assign M6 = r_m[5];

endmodule
